// File: rtl/pchk_pkg.sv
// ---------------------------------------------------------------------------
// pchk_pkg
// Shared definitions for the MMIO node-path checker:
//   - pchkState_e       : checker FSM states (LOAD / RUN / FINISH)
//   - DEFAULT_NODE_ADDR : address the CPU writes each node value to
//   - DEFAULT_DONE_ADDR : address the CPU writes 1 to when it has finished
//   - sat_inc()         : increment that sticks at a caller-supplied limit
// ---------------------------------------------------------------------------
package pchk_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } pchkState_e;

    localparam logic [31:0] DEFAULT_NODE_ADDR = 32'h0200_0008;
    localparam logic [31:0] DEFAULT_DONE_ADDR = 32'h0200_000C;

    // Callers zero-extend their counter into 32 bits and cast the result back,
    // so a single helper serves every counter width in the design.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/mmio_path_checker_if.sv
// ---------------------------------------------------------------------------
// mmio_path_checker_if
// Bundles the two buses the checker listens to:
//   - expected-list load channel : ld_valid, ld_data (to checker), ld_ready (from checker)
//   - snooped CPU data write bus : mem_we, mem_addr, mem_wdata (to checker)
// Modports:
//   master : the side that loads the list and owns the CPU bus
//   slave  : the checker
// ---------------------------------------------------------------------------
interface mmio_path_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ld_valid, ld_data, mem_we, mem_addr, mem_wdata,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_data, mem_we, mem_addr, mem_wdata,
        output ld_ready
    );

endinterface

// File: rtl/pchk_list_ram.sv
// ---------------------------------------------------------------------------
// pchk_list_ram
// DEPTH x DATA_W simple dual-port RAM holding the expected node list.
// One write port, one read port with a registered (synchronous) read, so it
// maps onto FPGA block RAM. Contents are not reset.
// Ports:
//   clk    : clock
//   wrEn   : write enable
//   wrAddr : write address
//   wrData : write data
//   rdAddr : read address, sampled on the rising edge
//   rdData : read data, valid the cycle after rdAddr is presented
// ---------------------------------------------------------------------------
module pchk_list_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [AW-1:0]     rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share one edge; the checker never writes and
    // reads in the same phase, so read-during-write behaviour does not matter.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/mmio_path_checker.sv
// ---------------------------------------------------------------------------
// mmio_path_checker
// Snoops CPU data-memory writes, compares every write to NODE_ADDR against a
// preloaded expected-node list and latches a pass/fail verdict when the CPU
// writes 1 to DONE_ADDR. Mismatches, overruns (more node writes than loaded
// entries) and an underrun (fewer) each add to a saturating error count.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous return to LOAD; list kept, counts zeroed
//   start        : LOAD -> RUN pulse
//   bus          : mmio_path_checker_if.slave (list load channel + CPU bus)
//   busy         : checker is in RUN
//   done, pass   : verdict latched / verdict value
//   err_count    : mismatch + overrun + underrun count (saturating)
//   node_count   : node writes checked (saturates at DEPTH)
//   exp_count    : expected entries loaded
//
// Optional macro PCHK_TRACE_EN adds first_err_valid/idx/exp/act, which hold
// the first failing node write of a run (exp reads 0 for an overrun).
// ---------------------------------------------------------------------------
module mmio_path_checker
    import pchk_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 16,
    parameter int                IDX_W     = $clog2(DEPTH) + 1,
    parameter int                ERR_W     = 8,
    parameter logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(DEFAULT_NODE_ADDR),
    parameter logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(DEFAULT_DONE_ADDR)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               start,
    mmio_path_checker_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [IDX_W-1:0]   node_count,
    output logic [IDX_W-1:0]   exp_count
`ifdef PCHK_TRACE_EN
    ,
    output logic               first_err_valid,
    output logic [IDX_W-1:0]   first_err_idx,
    output logic [DATA_W-1:0]  first_err_exp,
    output logic [DATA_W-1:0]  first_err_act
`endif
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    pchkState_e        state;
    pchkState_e        nextState;

    logic              ldReady;
    logic              loadFire;
    logic              nodeWrite;
    logic              doneWrite;
    logic [DATA_W-1:0] listRdData;

    logic              cmpValid;
    logic              cmpOverrun;
    logic [DATA_W-1:0] cmpAct;
    logic              cmpMismatch;
    logic              verdictStage1;
    logic              verdictStage2;
    logic              underrunFlag;
    logic              errInc;

    logic [IDX_W-1:0]  expCountInc;
    logic [IDX_W-1:0]  nodeCountInc;
    logic [ERR_W-1:0]  errCountInc;

`ifdef PCHK_TRACE_EN
    logic [IDX_W-1:0]  cmpIdx;
`endif

    // Bus decode. Node and done writes only count while running; a done
    // write must carry exactly 1 so stray stores to that address are ignored.
    assign ldReady   = (state == LOAD) && (exp_count < DEPTH_IDX);
    assign loadFire  = (state == LOAD) && !clr && bus.ld_valid && ldReady;
    assign nodeWrite = (state == RUN) && bus.mem_we && (bus.mem_addr == NODE_ADDR);
    assign doneWrite = (state == RUN) && bus.mem_we && (bus.mem_addr == DONE_ADDR)
                       && (bus.mem_wdata == DATA_W'(1));

    assign bus.ld_ready = ldReady;
    assign busy         = (state == RUN);

    assign expCountInc  = IDX_W'(sat_inc(32'(exp_count), 32'(DEPTH)));
    assign nodeCountInc = IDX_W'(sat_inc(32'(node_count), 32'(DEPTH)));
    assign errCountInc  = ERR_W'(sat_inc(32'(err_count), 32'(ERR_MAX)));

    // The compare is resolved one cycle after the node write, once the
    // registered list read is available. An underrun is charged one cycle
    // after the done write, which is always after any in-flight compare, so
    // the two error sources never need to add in the same cycle.
    assign cmpMismatch = cmpOverrun || (cmpAct != listRdData);
    assign errInc      = (cmpValid && cmpMismatch) || (verdictStage1 && underrunFlag);

    // The RAM is read at node_count every cycle; at the edge that samples a
    // node write this yields the entry that write must be compared against.
    pchk_list_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) listRam (
        .clk    (clk),
        .wrEn   (loadFire),
        .wrAddr (exp_count[AW-1:0]),
        .wrData (bus.ld_data),
        .rdAddr (node_count[AW-1:0]),
        .rdData (listRdData)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. clr wins everywhere; start only matters in LOAD, and
    // FINISH waits for clr so the verdict stays visible to the wrapper.
    always_comb begin
        nextState = state;
        case (state)
            LOAD:    if (!clr && start) nextState = RUN;
            RUN:     if (clr) nextState = LOAD;
                     else if (doneWrite) nextState = FINISH;
            FINISH:  if (clr) nextState = LOAD;
            default: nextState = LOAD;
        endcase
    end

    // Counters, compare pipeline and verdict. clr and start both wipe the
    // per-run results; only clr also forgets how many entries were loaded.
    // A load and a start in the same cycle both take effect on this edge.
    // The verdict is two stages behind the done write: stage 1 charges the
    // underrun, stage 2 latches pass from the then-final error count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_count     <= '0;
            node_count    <= '0;
            err_count     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            cmpValid      <= 1'b0;
            cmpOverrun    <= 1'b0;
            cmpAct        <= '0;
            verdictStage1 <= 1'b0;
            verdictStage2 <= 1'b0;
            underrunFlag  <= 1'b0;
`ifdef PCHK_TRACE_EN
            cmpIdx          <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
`endif
        end else if (clr) begin
            exp_count     <= '0;
            node_count    <= '0;
            err_count     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            cmpValid      <= 1'b0;
            verdictStage1 <= 1'b0;
            verdictStage2 <= 1'b0;
            underrunFlag  <= 1'b0;
`ifdef PCHK_TRACE_EN
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
`endif
        end else begin
            if (loadFire) begin
                exp_count <= expCountInc;
            end

            if ((state == LOAD) && start) begin
                node_count    <= '0;
                err_count     <= '0;
                done          <= 1'b0;
                pass          <= 1'b0;
                cmpValid      <= 1'b0;
                verdictStage1 <= 1'b0;
                verdictStage2 <= 1'b0;
                underrunFlag  <= 1'b0;
`ifdef PCHK_TRACE_EN
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_exp   <= '0;
                first_err_act   <= '0;
`endif
            end else begin
                cmpValid <= nodeWrite;
                if (nodeWrite) begin
                    cmpOverrun <= (node_count >= exp_count);
                    cmpAct     <= bus.mem_wdata;
                    node_count <= nodeCountInc;
`ifdef PCHK_TRACE_EN
                    cmpIdx     <= node_count;
`endif
                end

                if (errInc) begin
                    err_count <= errCountInc;
                end

`ifdef PCHK_TRACE_EN
                if (cmpValid && cmpMismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= cmpIdx;
                    first_err_exp   <= cmpOverrun ? '0 : listRdData;
                    first_err_act   <= cmpAct;
                end
`endif

                verdictStage1 <= doneWrite;
                if (doneWrite) begin
                    underrunFlag <= (node_count < exp_count);
                end
                verdictStage2 <= verdictStage1;
                if (verdictStage2) begin
                    done <= 1'b1;
                    pass <= (err_count == '0) && (node_count != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_path_checker.sv
// ---------------------------------------------------------------------------
// tb_mmio_path_checker
// Self-checking bench for mmio_path_checker. A second instance with DEPTH=4
// and ERR_W=2 mirrors the same traffic to exercise counter saturation.
// Expected verdicts come from modelVerdict(), which scores the loaded list
// and the node writes directly from the checking rules.
// ---------------------------------------------------------------------------
module tb_mmio_path_checker;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 5;
    localparam int ERR_W  = 8;
    localparam int DEPTH2 = 4;
    localparam int IDX_W2 = 3;
    localparam int ERR_W2 = 2;
    localparam logic [31:0] NODE_A = 32'h0200_0008;
    localparam logic [31:0] DONE_A = 32'h0200_000C;

    logic clk;
    logic reset_n;
    logic clr;
    logic start;

    logic              busy, done, pass;
    logic [ERR_W-1:0]  errCount;
    logic [IDX_W-1:0]  nodeCount, expCount;
    logic              busy2, done2, pass2;
    logic [ERR_W2-1:0] errCount2;
    logic [IDX_W2-1:0] nodeCount2, expCount2;

`ifdef PCHK_TRACE_EN
    logic              ferrValid, ferrValid2;
    logic [IDX_W-1:0]  ferrIdx;
    logic [IDX_W2-1:0] ferrIdx2;
    logic [31:0]       ferrExp, ferrAct, ferrExp2, ferrAct2;
`endif

    int checks;
    int failures;
    logic [31:0] loadList[$];
    logic [31:0] nodeList[$];

    mmio_path_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();
    mmio_path_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf2 ();

    // The small instance sees exactly the same traffic as the main one.
    assign busIf2.ld_valid  = busIf.ld_valid;
    assign busIf2.ld_data   = busIf.ld_data;
    assign busIf2.mem_we    = busIf.mem_we;
    assign busIf2.mem_addr  = busIf.mem_addr;
    assign busIf2.mem_wdata = busIf.mem_wdata;

    mmio_path_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .start(start), .bus(busIf),
        .busy(busy), .done(done), .pass(pass), .err_count(errCount),
        .node_count(nodeCount), .exp_count(expCount)
`ifdef PCHK_TRACE_EN
        , .first_err_valid(ferrValid), .first_err_idx(ferrIdx),
        .first_err_exp(ferrExp), .first_err_act(ferrAct)
`endif
    );

    mmio_path_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH2), .IDX_W(IDX_W2), .ERR_W(ERR_W2)
    ) dutSat (
        .clk(clk), .reset_n(reset_n), .clr(clr), .start(start), .bus(busIf2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(errCount2),
        .node_count(nodeCount2), .exp_count(expCount2)
`ifdef PCHK_TRACE_EN
        , .first_err_valid(ferrValid2), .first_err_idx(ferrIdx2),
        .first_err_exp(ferrExp2), .first_err_act(ferrAct2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: score the node writes against the list as it would
    // have been accepted by a checker of the given depth and counter limit.
    task automatic modelVerdict(input int depth, input int errMax, output int errExp,
                                output int nodeExp, output int expExp, output bit passExp);
        int errs;
        errs   = 0;
        expExp = (loadList.size() < depth) ? loadList.size() : depth;
        foreach (nodeList[i]) begin
            if (i < expExp) begin
                if (nodeList[i] != loadList[i]) errs++;
            end else begin
                errs++;
            end
        end
        if (nodeList.size() < expExp) errs++;
        passExp = (errs == 0) && (nodeList.size() > 0);
        errExp  = (errs > errMax) ? errMax : errs;
        nodeExp = (nodeList.size() < depth) ? nodeList.size() : depth;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busIdle();
        busIf.ld_valid  = 1'b0;
        busIf.ld_data   = '0;
        busIf.mem_we    = 1'b0;
        busIf.mem_addr  = '0;
        busIf.mem_wdata = '0;
        clr   = 1'b0;
        start = 1'b0;
    endtask

    // One bus cycle on the snooped CPU write port.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        busIf.mem_we    = we;
        busIf.mem_addr  = addr;
        busIf.mem_wdata = wdata;
        step();
        busIf.mem_we    = 1'b0;
    endtask

    task automatic injectNoise();
        case ($urandom_range(0, 3))
            0:       applyStimulus(1'b0, NODE_A, $urandom);
            1:       applyStimulus(1'b1, DONE_A, ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(2, 50)));
            2:       applyStimulus(1'b1, 32'h0200_0010, $urandom);
            default: applyStimulus(1'b1, 32'h0200_0004, 32'd1);
        endcase
    endtask

    task automatic prepareRun();
        clr = 1'b1;
        step();
        clr = 1'b0;
        foreach (loadList[i]) begin
            busIf.ld_valid = 1'b1;
            busIf.ld_data  = loadList[i];
            step();
        end
        busIf.ld_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic driveNodes(input bit noisy);
        foreach (nodeList[i]) begin
            if (noisy && $urandom_range(0, 3) == 0) injectNoise();
            applyStimulus(1'b1, NODE_A, nodeList[i]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, pass, busIf.ld_ready} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset flags busy/done/pass/ld_ready: got %b want 0001", {busy, done, pass, busIf.ld_ready});
        end
        checks++;
        if ({errCount, nodeCount, expCount} !== '0) begin
            failures++;
            $display("[TB] FAIL reset counts: got err=%0d node=%0d exp=%0d want all 0", errCount, nodeCount, expCount);
        end
        checks++;
        if ({busy2, done2, pass2, errCount2, nodeCount2, expCount2} !== '0) begin
            failures++;
            $display("[TB] FAIL reset small instance: got err=%0d node=%0d exp=%0d want all 0", errCount2, nodeCount2, expCount2);
        end
    endtask

    task automatic test_match();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd5, 32'd3, 32'd7, 32'd9};
        nodeList = '{32'd5, 32'd3, 32'd7, 32'd9};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        checks++;
        if ({busy, busIf.ld_ready} !== 2'b10 || expCount !== IDX_W'(expExp)) begin
            failures++;
            $display("[TB] FAIL match run entry: got busy=%b ld_ready=%b exp=%0d want 1 0 %0d", busy, busIf.ld_ready, expCount, expExp);
        end
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL match done write: got busy=%b done=%b want 0 0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL match verdict early: got done=%b want 0", done);
        end
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp) || nodeCount !== IDX_W'(nodeExp)) begin
            failures++;
            $display("[TB] FAIL match verdict: got done=%b pass=%b err=%0d node=%0d want 1 %b %0d %0d",
                     done, pass, errCount, nodeCount, passExp, errExp, nodeExp);
        end
        // A finished checker ignores start and further node writes.
        start = 1'b1;
        step();
        start = 1'b0;
        applyStimulus(1'b1, NODE_A, 32'd77);
        step();
        checks++;
        if ({busy, done, pass} !== {1'b0, 1'b1, passExp} || nodeCount !== IDX_W'(nodeExp) || errCount !== ERR_W'(errExp)) begin
            failures++;
            $display("[TB] FAIL finish hold: got busy=%b done=%b pass=%b node=%0d err=%0d want 0 1 %b %0d %0d",
                     busy, done, pass, nodeCount, errCount, passExp, nodeExp, errExp);
        end
    endtask

    task automatic test_mismatch();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd5, 32'd3, 32'd7, 32'd9};
        nodeList = '{32'd5, 32'd4, 32'd7, 32'd9};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp)) begin
            failures++;
            $display("[TB] FAIL mismatch verdict: got done=%b pass=%b err=%0d want 1 %b %0d", done, pass, errCount, passExp, errExp);
        end
`ifdef PCHK_TRACE_EN
        checks++;
        if ({ferrValid, ferrIdx} !== {1'b1, 5'd1} || ferrExp !== 32'd3 || ferrAct !== 32'd4) begin
            failures++;
            $display("[TB] FAIL mismatch trace: got v=%b idx=%0d exp=%0d act=%0d want 1 1 3 4", ferrValid, ferrIdx, ferrExp, ferrAct);
        end
`endif
    endtask

    task automatic test_overrun();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd5, 32'd3};
        nodeList = '{32'd5, 32'd3, 32'd8};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp) || nodeCount !== IDX_W'(nodeExp)) begin
            failures++;
            $display("[TB] FAIL overrun verdict: got done=%b pass=%b err=%0d node=%0d want 1 %b %0d %0d",
                     done, pass, errCount, nodeCount, passExp, errExp, nodeExp);
        end
`ifdef PCHK_TRACE_EN
        checks++;
        if ({ferrValid, ferrIdx} !== {1'b1, 5'd2} || ferrExp !== 32'd0 || ferrAct !== 32'd8) begin
            failures++;
            $display("[TB] FAIL overrun trace: got v=%b idx=%0d exp=%0d act=%0d want 1 2 0 8", ferrValid, ferrIdx, ferrExp, ferrAct);
        end
`endif
    endtask

    task automatic test_underrun();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd5, 32'd3, 32'd7, 32'd9};
        nodeList = '{32'd5, 32'd3};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp)) begin
            failures++;
            $display("[TB] FAIL underrun verdict: got done=%b pass=%b err=%0d want 1 %b %0d", done, pass, errCount, passExp, errExp);
        end
        // Same list, no node writes at all.
        nodeList = {};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp) || nodeCount !== '0) begin
            failures++;
            $display("[TB] FAIL no-writes verdict: got done=%b pass=%b err=%0d node=%0d want 1 %b %0d 0",
                     done, pass, errCount, nodeCount, passExp, errExp);
        end
    endtask

    task automatic test_err_latency();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd5, 32'd3};
        nodeList = '{32'd4};
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        prepareRun();
        applyStimulus(1'b1, NODE_A, 32'd4);
        checks++;
        if (errCount !== '0) begin
            failures++;
            $display("[TB] FAIL err latency write cycle: got err=%0d want 0", errCount);
        end
        step();
        checks++;
        if (errCount !== ERR_W'(1)) begin
            failures++;
            $display("[TB] FAIL err latency next cycle: got err=%0d want 1", errCount);
        end
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp)) begin
            failures++;
            $display("[TB] FAIL err latency verdict: got done=%b pass=%b err=%0d want 1 %b %0d", done, pass, errCount, passExp, errExp);
        end
    endtask

    task automatic test_done_filter();
        loadList = '{32'd5};
        nodeList = '{32'd5};
        prepareRun();
        applyStimulus(1'b1, DONE_A, 32'd0);
        applyStimulus(1'b1, DONE_A, 32'd2);
        applyStimulus(1'b0, DONE_A, 32'd1);
        applyStimulus(1'b0, NODE_A, 32'd5);
        step();
        checks++;
        if ({busy, done} !== 2'b10 || nodeCount !== '0 || errCount !== '0) begin
            failures++;
            $display("[TB] FAIL done filter: got busy=%b done=%b node=%0d err=%0d want 1 0 0 0", busy, done, nodeCount, errCount);
        end
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL done filter verdict: got done=%b pass=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_overfill();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = {};
        for (int i = 0; i < DEPTH + 1; i++) loadList.push_back(32'($urandom_range(0, 1000)));
        nodeList = loadList[0:DEPTH-1];
        modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
        clr = 1'b1;
        step();
        clr = 1'b0;
        foreach (loadList[i]) begin
            busIf.ld_valid = 1'b1;
            busIf.ld_data  = loadList[i];
            step();
        end
        busIf.ld_valid = 1'b0;
        checks++;
        if (busIf.ld_ready !== 1'b0 || expCount !== IDX_W'(expExp)) begin
            failures++;
            $display("[TB] FAIL overfill: got ld_ready=%b exp=%0d want 0 %0d", busIf.ld_ready, expCount, expExp);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp) || nodeCount !== IDX_W'(nodeExp)) begin
            failures++;
            $display("[TB] FAIL full list verdict: got done=%b pass=%b err=%0d node=%0d want 1 %b %0d %0d",
                     done, pass, errCount, nodeCount, passExp, errExp, nodeExp);
        end
    endtask

    task automatic test_saturation();
        int errExp, nodeExp, expExp;
        bit passExp;
        loadList = '{32'd1, 32'd2, 32'd3, 32'd4};
        nodeList = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
        modelVerdict(DEPTH2, 3, errExp, nodeExp, expExp, passExp);
        prepareRun();
        driveNodes(1'b0);
        applyStimulus(1'b1, DONE_A, 32'd1);
        step();
        step();
        checks++;
        if (errCount2 !== ERR_W2'(errExp) || nodeCount2 !== IDX_W2'(nodeExp) || {done2, pass2} !== {1'b1, passExp}) begin
            failures++;
            $display("[TB] FAIL saturation: got err=%0d node=%0d done=%b pass=%b want %0d %0d 1 %b",
                     errCount2, nodeCount2, done2, pass2, errExp, nodeExp, passExp);
        end
        checks++;
        if (errCount !== ERR_W'(5)) begin
            failures++;
            $display("[TB] FAIL unsaturated count: got err=%0d want 5", errCount);
        end
    endtask

    task automatic test_reset_mid_run();
        loadList = '{32'd5, 32'd3, 32'd7, 32'd9};
        nodeList = '{32'd5, 32'd3};
        prepareRun();
        driveNodes(1'b0);
        checks++;
        if (busy !== 1'b1 || nodeCount !== IDX_W'(2)) begin
            failures++;
            $display("[TB] FAIL pre-reset run: got busy=%b node=%0d want 1 2", busy, nodeCount);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, busIf.ld_ready} !== 4'b0001 || {errCount, nodeCount, expCount} !== '0) begin
            failures++;
            $display("[TB] FAIL async reset: got flags=%b err=%0d node=%0d exp=%0d want 0001 0 0 0",
                     {busy, done, pass, busIf.ld_ready}, errCount, nodeCount, expCount);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (expCount !== '0 || busIf.ld_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after reset release: got exp=%0d ld_ready=%b busy=%b want 0 1 0", expCount, busIf.ld_ready, busy);
        end
    endtask

    task automatic test_random();
        int errExp, nodeExp, expExp, errExp2, nodeExp2, expExp2;
        bit passExp, passExp2;
        int nLoad, nNode;
        for (int iter = 0; iter < 12; iter++) begin
            nLoad = $urandom_range(1, DEPTH + 2);
            nNode = $urandom_range(0, DEPTH + 2);
            loadList = {};
            nodeList = {};
            for (int i = 0; i < nLoad; i++) loadList.push_back(32'($urandom_range(0, 7)));
            for (int i = 0; i < nNode; i++) begin
                if (i < nLoad && $urandom_range(0, 2) != 0) nodeList.push_back(loadList[i]);
                else nodeList.push_back(32'($urandom_range(0, 7)));
            end
            modelVerdict(DEPTH, 255, errExp, nodeExp, expExp, passExp);
            modelVerdict(DEPTH2, 3, errExp2, nodeExp2, expExp2, passExp2);
            prepareRun();
            driveNodes(1'b1);
            applyStimulus(1'b1, DONE_A, 32'd1);
            step();
            step();
            checks++;
            if ({done, pass} !== {1'b1, passExp} || errCount !== ERR_W'(errExp)
                || nodeCount !== IDX_W'(nodeExp) || expCount !== IDX_W'(expExp)) begin
                failures++;
                $display("[TB] FAIL random %0d: got done=%b pass=%b err=%0d node=%0d exp=%0d want 1 %b %0d %0d %0d",
                         iter, done, pass, errCount, nodeCount, expCount, passExp, errExp, nodeExp, expExp);
            end
            checks++;
            if ({done2, pass2} !== {1'b1, passExp2} || errCount2 !== ERR_W2'(errExp2) || nodeCount2 !== IDX_W2'(nodeExp2)) begin
                failures++;
                $display("[TB] FAIL random small %0d: got done=%b pass=%b err=%0d node=%0d want 1 %b %0d %0d",
                         iter, done2, pass2, errCount2, nodeCount2, passExp2, errExp2, nodeExp2);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        busIdle();
        #12;
        test_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        test_match();
        test_mismatch();
        test_overrun();
        test_underrun();
        test_err_latency();
        test_done_filter();
        test_overfill();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: time limit reached before the test sequence ended");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
